mult_row_sequencer: RTL and testbench

- Initiator for the multiplier's begin_mult/done_row handshake.
- On start, walks row_select 0..NUM_ROWS-1 and issues one begin_mult pulse per row.
- Waits for done_row on each row, captures row_result, and keeps a running signed argmax.
- After the last row, reports the winning class index and its score. Sits between the top-level controller and the multiplier.

---
 rtl/mult_row_sequencer.sv | 120 ++++++++++++
 tb/tb_mult_row_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_row_sequencer.sv
// Row sequencer: issues one multiplier launch per output row.
// It tracks a signed running argmax and reports the best class.
module mult_row_sequencer #(
  parameter int NUM_ROWS       = 10,
  parameter int RESULT_W       = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic [3:0]          row_select,
  output logic                begin_mult,
  input  logic                done_row,
  input  logic [RESULT_W-1:0] row_result,
  output logic                done,
  output logic                error,
  output logic [3:0]          class_out,
  output logic [RESULT_W-1:0] max_value
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RESULT_W-1:0] MOST_NEG =
    {1'b1, {(RESULT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RELEASE,
    S_FINISH
  } state_t;

  state_t state, state_nx;

  logic [3:0]                 row_cnt;
  logic [3:0]                 best_idx;
  logic signed [RESULT_W-1:0] best_val;
  logic signed [RESULT_W-1:0] res_q;
  logic [TW-1:0]              tcnt;

  assign busy       = (state != S_IDLE);
  assign begin_mult = (state == S_ISSUE);
  assign done       = (state == S_FINISH);
  assign row_select = row_cnt;

  always_comb begin
    state_nx = state;
    error    = 1'b0;
    unique case (state)
      S_IDLE:    if (start) state_nx = S_ISSUE;
      S_ISSUE:   state_nx = S_WAIT;
      S_WAIT: begin
        if (done_row) begin
          state_nx = S_CAPTURE;
        end else if (tcnt == T_LAST) begin
          error    = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_CAPTURE: state_nx = S_RELEASE;
      // Level-style done_row must fall before the next row launches.
      S_RELEASE: begin
        if (!done_row)
          state_nx = (row_cnt == LAST_ROW) ? S_FINISH : S_ISSUE;
      end
      S_FINISH:  state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      tcnt      <= '0;
      best_idx  <= '0;
      best_val  <= MOST_NEG;
      res_q     <= '0;
      class_out <= '0;
      max_value <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          best_idx <= '0;
          best_val <= MOST_NEG;
          if (start) row_cnt <= '0;
        end
        S_ISSUE: tcnt <= '0;
        S_WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (done_row) res_q <= row_result;
        end
        // Strict compare: ties keep the lower index.
        S_CAPTURE: begin
          if (res_q > best_val) begin
            best_idx <= row_cnt;
            best_val <= res_q;
          end
        end
        S_RELEASE: begin
          if (!done_row) begin
            if (row_cnt == LAST_ROW) begin
              class_out <= best_idx;
              max_value <= best_val;
            end else begin
              row_cnt <= row_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_row_sequencer.sv
// Bench for mult_row_sequencer: table of passes against a
// behavioural multiplier, plus a reset-abort sequence.
module tb_mult_row_sequencer;

  localparam int NR = 10;
  localparam int RW = 16;
  localparam int TO = 1023;
  localparam int BUDGET = 6000;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic [3:0]    row_select;
  logic          begin_mult;
  logic          done_row;
  logic [RW-1:0] row_result;
  logic          done;
  logic          error;
  logic [3:0]    class_out;
  logic [RW-1:0] max_value;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tb_clk = ~tb_clk;

  mult_row_sequencer #(
    .NUM_ROWS(NR),
    .RESULT_W(RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(tb_clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .row_select(row_select),
    .begin_mult(begin_mult),
    .done_row(done_row),
    .row_result(row_result),
    .done(done),
    .error(error),
    .class_out(class_out),
    .max_value(max_value)
  );

  typedef struct {
    int            delay;
    int            hold;
    int            skip;
    logic [RW-1:0] res [NR];
    int            exp_cls;
    logic [RW-1:0] exp_max;
    bit            exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " row_select"}, 32'(row_select), 0);
    chk({tag, " begin_mult"}, 32'(begin_mult), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " error"}, 32'(error), 0);
    chk({tag, " class_out"}, 32'(class_out), 0);
    chk({tag, " max_value"}, 32'(max_value), 0);
  endtask

  task automatic run_pass(input vec_t v, input int abort_row);
    int  nbeg, ndone, nerr, cur_row, beg_cyc, done_cyc;
    int  err_cyc, err_exp;
    bit  fin;
    nbeg = 0; ndone = 0; nerr = 0; cur_row = 0;
    beg_cyc = -100; done_cyc = -1; err_cyc = -1; err_exp = -1;
    fin = 0;
    @(negedge tb_clk);
    start = 1'b1;
    done_row = 1'b0;
    for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
      @(negedge tb_clk);
      start = (cyc == 6);
      if (cyc == 1) chk("busy after start", 32'(busy), 1);
      if (begin_mult) begin
        chk("row order", 32'(row_select), 32'(nbeg));
        cur_row = int'(row_select);
        beg_cyc = cyc;
        nbeg++;
        if (cur_row == v.skip) err_exp = cyc + TO;
      end
      if (abort_row >= 0 && nbeg == abort_row + 1 &&
          cyc == beg_cyc + 1) begin
        rst = 1'b1;
        start = 1'b1;
        done_row = 1'b0;
        @(posedge tb_clk);
        #1;
        chk_reset_outs("abort");
        chk("abort begins", 32'(nbeg), 32'(abort_row + 1));
        chk("abort no done", 32'(ndone + nerr), 0);
        @(negedge tb_clk);
        rst = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge tb_clk);
          chk("post-abort quiet",
              32'({busy, begin_mult, done, error}), 0);
        end
        return;
      end
      done_row = (nbeg > 0) && (cur_row != v.skip) &&
                 (cyc >= beg_cyc + v.delay) &&
                 (cyc < beg_cyc + v.delay + v.hold);
      row_result = v.res[cur_row];
      #1;
      if (error) begin
        nerr++;
        err_cyc = cyc;
        fin = 1;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        fin = 1;
        chk("class at done", 32'(class_out), 32'(v.exp_cls));
        chk("max at done", 32'(max_value), 32'(v.exp_max));
      end
    end
    done_row = 1'b0;
    start = 1'b0;
    if (!fin) chk("cycle budget", 0, 1);
    chk("done count", 32'(ndone), v.exp_err ? 0 : 1);
    chk("error count", 32'(nerr), v.exp_err ? 1 : 0);
    chk("begin count", 32'(nbeg), v.exp_err ? 32'(v.skip + 1) : NR);
    if (v.exp_err) chk("error timing", 32'(err_cyc), 32'(err_exp));
    if (!v.exp_err && v.delay == 1 && v.hold == 1)
      chk("min latency", 32'(done_cyc), 1 + NR * 4);
    @(negedge tb_clk);
    chk("busy after pass", 32'(busy), 0);
    chk("class held", 32'(class_out), 32'(v.exp_cls));
    chk("max held", 32'(max_value), 32'(v.exp_max));
  endtask

  initial begin
    vecs[0].delay = 392; vecs[0].hold = 1; vecs[0].skip = -1;
    vecs[0].res = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 90};
    vecs[0].exp_cls = 9; vecs[0].exp_max = 16'd90; vecs[0].exp_err = 0;

    vecs[1].delay = 1; vecs[1].hold = 1; vecs[1].skip = -1;
    vecs[1].res = '{5, 9, 3, 9, 1, 0, 0, 0, 0, 0};
    vecs[1].exp_cls = 1; vecs[1].exp_max = 16'd9; vecs[1].exp_err = 0;

    vecs[2].delay = 2; vecs[2].hold = 1; vecs[2].skip = -1;
    vecs[2].res = '{16'hFFF9, 16'hFFFD, 16'hFF9C, 16'hFFFD, 16'hFFF8,
                    16'hFFF7, 16'hFFF7, 16'hFFF7, 16'hFFF7, 16'hFFF7};
    vecs[2].exp_cls = 1; vecs[2].exp_max = 16'hFFFD; vecs[2].exp_err = 0;

    vecs[3].delay = 1; vecs[3].hold = 1; vecs[3].skip = -1;
    vecs[3].res = '{default: 16'h8000};
    vecs[3].exp_cls = 0; vecs[3].exp_max = 16'h8000; vecs[3].exp_err = 0;

    vecs[4].delay = 1; vecs[4].hold = 5; vecs[4].skip = -1;
    vecs[4].res = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    vecs[4].exp_cls = 5; vecs[4].exp_max = 16'd9; vecs[4].exp_err = 0;

    vecs[5].delay = 3; vecs[5].hold = 1; vecs[5].skip = 3;
    vecs[5].res = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    vecs[5].exp_cls = 5; vecs[5].exp_max = 16'd9; vecs[5].exp_err = 1;

    vecs[6].delay = 1; vecs[6].hold = 1; vecs[6].skip = -1;
    vecs[6].res = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 90};
    vecs[6].exp_cls = 9; vecs[6].exp_max = 16'd90; vecs[6].exp_err = 0;

    rst = 1'b1;
    start = 1'b0;
    done_row = 1'b0;
    row_result = '0;
    repeat (3) @(negedge tb_clk);
    chk_reset_outs("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_pass(vecs[i], -1);

    run_pass(vecs[4], 5);
    chk_reset_outs("after abort");
    run_pass(vecs[6], -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
